// File: rtl/fsm_ab_tx_if.sv
// Parallel-in / serial-out bus for the "101" pattern transmitter.
// The master side supplies words and the counter clear; the slave side
// (the transmitter) returns the serial stream and the expected-match count.
interface fsm_ab_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             bit_out;
  logic             bit_valid;
  logic             done;
  logic             clear_cnt;
  logic [CNT_W-1:0] expect_cnt;

  modport master (
    output data_in, valid_in, clear_cnt,
    input  ready_out, bit_out, bit_valid, done, expect_cnt
  );

  modport slave (
    input  data_in, valid_in, clear_cnt,
    output ready_out, bit_out, bit_valid, done, expect_cnt
  );
endinterface

// File: rtl/fsm_ab_tx.sv
// Serial pattern transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out MSB-first with no gap between back-to-back words. A copy
// of the downstream "101" detector watches bit_out and keeps a saturating
// count of the detections the real detector should report.
module fsm_ab_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic        clock,
  input logic        reset,
  fsm_ab_tx_if.slave bus
);

  localparam int RW = $clog2(WIDTH);
  localparam logic [RW-1:0] REM_LOAD = RW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    T_S0,
    T_S1,
    T_S2,
    T_S3
  } det_t;

  state_t           state;
  logic [RW-1:0]    rem;      // bits still to send after the current one
  logic [WIDTH-2:0] shreg;    // bits below the one currently on bit_out
  logic             bit_q;
  logic             valid_q;
  logic             done_q;
  det_t             det;
  det_t             det_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Ready while idle or while the LSB is on the wire, so the next word's
  // MSB can follow the current LSB without an idle bit.
  assign bus.ready_out = (state == IDLE) || (rem == '0);
  assign accept        = bus.valid_in && bus.ready_out;

  assign bus.bit_out    = bit_q;
  assign bus.bit_valid  = valid_q;
  assign bus.done       = done_q;
  assign bus.expect_cnt = cnt;

  // Detector model next state from the bit currently on the wire.
  always_comb begin
    // NOTE: default first so every path assigns det_next and no latch is inferred.
    det_next = T_S0;
    unique case (det)
      T_S0: det_next = bit_q ? T_S1 : T_S0;
      T_S1: det_next = bit_q ? T_S1 : T_S2;
      T_S2: det_next = bit_q ? T_S3 : T_S0;
      T_S3: det_next = bit_q ? T_S1 : T_S2;
      default: det_next = T_S0;
    endcase
  end

  // Transmit FSM: load on accept, shift while bits remain, else go idle.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= IDLE;
      rem     <= '0;
      shreg   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      state   <= SHIFT;
      bit_q   <= bus.data_in[WIDTH-1];
      shreg   <= bus.data_in[WIDTH-2:0];
      rem     <= REM_LOAD;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (state == SHIFT && rem != '0) begin
      bit_q   <= shreg[WIDTH-2];
      shreg   <= shreg << 1;
      rem     <= rem - RW'(1);
      done_q  <= (rem == RW'(1));
    end else begin
      state   <= IDLE;
      rem     <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  // Detector model state and saturating expected-match counter; clear wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      det <= T_S0;
      cnt <= '0;
    end else begin
      det <= det_next;
      if (bus.clear_cnt) begin
        cnt <= '0;
      end else if (det_next == T_S3 && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_ab_tx.sv
// Self-checking bench for fsm_ab_tx. Accepted words push their expected
// serial bits onto a scoreboard; a negedge monitor pops and compares them
// against bit_out/bit_valid/done/ready_out. Scenario tasks check counts.
module tb_fsm_ab_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fsm_ab_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fsm_ab_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stream monitor: compares every cycle against the scoreboard head.
  always @(negedge clock) begin
    if (mon_en) begin
      exp_t e;
      logic ev, eb, ed, er;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ev = 1'b1;
        eb = e.b;
        ed = e.d;
        er = e.d;
      end else begin
        ev = 1'b0;
        eb = 1'b0;
        ed = 1'b0;
        er = 1'b1;
      end
      n_checks++;
      if ({bus.bit_valid, bus.bit_out, bus.done, bus.ready_out} !== {ev, eb, ed, er}) begin
        n_fail++;
        $display("FAIL stream @%0t: valid/bit/done/ready got %b%b%b%b expected %b%b%b%b",
                 $time, bus.bit_valid, bus.bit_out, bus.done, bus.ready_out, ev, eb, ed, er);
      end
    end
  end

  // Offer a word and wait (bounded) for the accept edge, then push its bits.
  task automatic send_word(input logic [WIDTH-1:0] w);
    logic r;
    bit   accepted;
    accepted     = 1'b0;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      r = bus.ready_out;
      tick();
      if (r) accepted = 1'b1;
    end
    bus.valid_in = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL accept_timeout: word %h not accepted, required acceptance within 100 cycles", w);
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        sb.push_back('{b: w[WIDTH-1-k], d: (k == WIDTH-1)});
      end
    end
  endtask

  // Wait (bounded) until every expected bit has been seen.
  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bits still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_count();
    tick();
    tick();
    bus.clear_cnt = 1'b1;
    tick();
    bus.clear_cnt = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.clear_cnt = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", bus.ready_out);
    end
    n_checks++;
    if ({bus.bit_out, bus.bit_valid, bus.done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: bit/valid/done got %b%b%b required 000",
                         bus.bit_out, bus.bit_valid, bus.done);
    end
    n_checks++;
    if (bus.expect_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d required 0", bus.expect_cnt);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    clear_count();
    send_word(8'hA5);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd2) begin
      n_fail++; $display("FAIL single_cnt: got %0d required 2", bus.expect_cnt);
    end
    tick();
    tick();
    n_checks++;
    if (bus.expect_cnt !== 2'd2) begin
      n_fail++; $display("FAIL single_cnt_hold: got %0d required 2", bus.expect_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_count();
    send_word(8'h02);
    send_word(8'h80);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd1) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d required 1", bus.expect_cnt);
    end
  endtask

  task automatic test_gap();
    clear_count();
    send_word(8'h02);
    drain();
    tick();
    tick();
    send_word(8'h80);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd0) begin
      n_fail++; $display("FAIL gap_cnt: got %0d required 0", bus.expect_cnt);
    end
  endtask

  task automatic test_saturation_clear();
    clear_count();
    send_word(8'h55);
    send_word(8'h55);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd3) begin
      n_fail++; $display("FAIL sat_cnt: got %0d required 3", bus.expect_cnt);
    end
    tick();
    bus.clear_cnt = 1'b1;
    tick();
    bus.clear_cnt = 1'b0;
    n_checks++;
    if (bus.expect_cnt !== 2'd0) begin
      n_fail++; $display("FAIL clear_cnt: got %0d required 0", bus.expect_cnt);
    end
    // 0x05 ends in a match on its LSB; clear lands on that same edge.
    tick();
    send_word(8'h05);
    repeat (WIDTH - 1) tick();
    n_checks++;
    if ({bus.done, bus.expect_cnt} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL pre_clear_match: done/cnt got %b/%0d required 1/0",
                         bus.done, bus.expect_cnt);
    end
    bus.clear_cnt = 1'b1;
    tick();
    bus.clear_cnt = 1'b0;
    n_checks++;
    if (bus.expect_cnt !== 2'd0) begin
      n_fail++; $display("FAIL clear_vs_match: got %0d required 0", bus.expect_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid_word();
    clear_count();
    send_word(8'h05);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd1) begin
      n_fail++; $display("FAIL pre_reset_cnt: got %0d required 1", bus.expect_cnt);
    end
    send_word(8'hFF);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    n_checks++;
    if ({bus.bit_valid, bus.bit_out, bus.ready_out} !== 3'b001) begin
      n_fail++; $display("FAIL midreset_outputs: valid/bit/ready got %b%b%b required 001",
                         bus.bit_valid, bus.bit_out, bus.ready_out);
    end
    n_checks++;
    if (bus.expect_cnt !== 2'd0) begin
      n_fail++; $display("FAIL midreset_cnt: got %0d required 0", bus.expect_cnt);
    end
    send_word(8'hA5);
    drain();
    n_checks++;
    if (bus.expect_cnt !== 2'd2) begin
      n_fail++; $display("FAIL post_reset_cnt: got %0d required 2", bus.expect_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_saturation_clear();
    test_reset_mid_word();
    repeat (3) tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fsm_ab_tx.md
# fsm_ab_tx

Serial pattern transmitter that drives the single-bit stream consumed by the team's "101" sequence-detector FSM. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, with no gaps between back-to-back words. It also runs a built-in model of the detector on its own output and keeps a saturating count of expected "101" detections, so a bench can check the downstream detector's `out` pulses against this count.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `CNT_W`, default 8: width of the expected-detection counter.
- `clock`, input, 1: sole clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high; one clock with the only clock, reset is synchronous and active-high.
- `data_in`, input, WIDTH: word to transmit; sampled on an accept edge.
- `valid_in`, input, 1: `data_in` is valid; once asserted, it and `data_in` are held until accepted.
- `ready_out`, output, 1: the transmitter can accept a word this cycle.
- `bit_out`, output, 1: serial data, registered; 0 whenever `bit_valid` = 0.
- `bit_valid`, output, 1: `bit_out` carries a word bit this cycle.
- `done`, output, 1: one-cycle pulse, high in the same cycle as the LSB of each word.
- `clear_cnt`, input, 1: synchronous clear of `expect_cnt`.
- `expect_cnt`, output, CNT_W: number of "101" detections the detector model has recorded on `bit_out`; saturating.

## Operation
- Accept: occurs at a posedge where `valid_in` & `ready_out` & !`reset`.
- States:
  - **IDLE**: `ready_out` = 1, `bit_valid` = 0, `bit_out` = 0.
  - **SHIFT**: a word is being transmitted; `rem` counts the bits left after the current one.
- IDLE→SHIFT on accept:
  - `bit_out` ← `data_in[WIDTH-1]`, `bit_valid` ← 1.
  - Remaining bits are loaded into the shift register; `rem` ← WIDTH-1.
- SHIFT with `rem` > 0:
  - Each edge presents the next lower bit and decrements `rem`.
  - `ready_out` = 0.
- SHIFT with `rem` = 0 (LSB cycle):
  - `done` = 1 and `ready_out` = 1.
  - If an accept occurs at this edge, the new word's MSB follows immediately: the state stays SHIFT and there is no idle bit.
  - Otherwise the state goes to IDLE, and `bit_out`/`bit_valid` return to 0.
- Detector model: a 2-bit state T, updated at every edge from the current `bit_out`. Idle zeros count as input, exactly as the detector sees them.
  - S0: 1→S1, 0→S0.
  - S1: 0→S2, 1→S1.
  - S2: 1→S3, 0→S0.
  - S3: 1→S1, 0→S2.
  - Matches therefore overlap.
- Counter rules:
  - `expect_cnt` increments at every edge where T's next state is S3.
  - It saturates at 2^CNT_W−1.
  - If `clear_cnt` is asserted at that edge, it sets the count to 0 and takes priority over the increment.
- Reset (at any time, including mid-word):
  - State goes to IDLE, T to S0, `expect_cnt` to 0.
  - `bit_out`, `bit_valid`, `done` go to 0; `ready_out` = 1.
  - The word in flight is discarded, and no accept happens at a reset edge.

## Timing
- Reset values: `ready_out` = 1; `bit_out`, `bit_valid`, `done`, `expect_cnt` = 0.
- Latency: for an accept at edge E, bit k (MSB = bit 0) is on `bit_out` in the cycle after edge E+k.
- The LSB and `done` appear in the cycle after edge E+WIDTH−1.
- Throughput: one word per WIDTH cycles when `valid_in` is held high.
- `expect_cnt` lags `bit_out` by one edge: a match whose final 1 is on `bit_out` in cycle c is reflected in `expect_cnt` from cycle c+1.
- `ready_out` is a combinational function of state and `rem` only. It does not depend on `valid_in`.

## Test plan
- **Reset:** hold `reset` 2 cycles → `ready_out` = 1, all other outputs 0, `expect_cnt` = 0.
- **Single word:** send 0xA5, then idle.
  - `bit_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `bit_valid` = 1.
  - `done` is high only on the 8th bit.
  - `expect_cnt` = 2 one cycle after `done`.
- **Back-to-back:** 0x02 then 0x80 with `valid_in` held.
  - The stream is 16 contiguous bits: `ready_out` is high on the LSB cycle of 0x02 and `bit_valid` never drops.
  - `expect_cnt` = 1 (cross-word match).
- **Gap:** 0x02, 3 idle cycles, then 0x80 → `expect_cnt` = 0.
- **Saturation and clear:** with CNT_W = 2, send 0x55, 0x55 back-to-back.
  - The model reaches 7 matches; `expect_cnt` saturates and stays at 3.
  - Pulsing `clear_cnt` → 0 next cycle.
  - A clear coinciding with a match edge → 0.
- **Reset mid-word:** assert `reset` while bit 3 of 0xFF is on `bit_out`.
  - Next cycle: `bit_valid` = 0, `bit_out` = 0, `ready_out` = 1, `expect_cnt` = 0.
  - A following word 0xA5 transmits normally, and `expect_cnt` reaches 2.
